// File: rtl/conv_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, digit width,
// add-3 correction constants and a power-of-ten helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam int ANCHO_DIG = 4;
  localparam logic [ANCHO_DIG-1:0] UMBRAL     = 4'd5;
  localparam logic [ANCHO_DIG-1:0] CORRECCION = 4'd3;

  function automatic int unsigned pot10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_bin_bcd_ajuste_dig.sv
// Per-digit add-3 correction applied before each double-dabble shift.
// Purely combinational, 4-bit wrap-around arithmetic.
module ajuste_dig
  import conv_pkg::*;
(
  input  logic [ANCHO_DIG-1:0] i_dig,
  output logic [ANCHO_DIG-1:0] o_dig
);

  assign o_dig = (i_dig >= UMBRAL) ? (i_dig + CORRECCION) : i_dig;

endmodule

// File: rtl/conv_bin_bcd.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock)
// with start/busy/done handshake. Saturation to all nines enabled by CONV_SAT_EN.
module conv_bin_bcd
  import conv_pkg::*;
#(
  parameter int ANCHO_BIN   = 8,
  parameter int NUM_DIGITOS = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           inicio,
  input  logic [ANCHO_BIN-1:0]           binario,
  output logic                           ocupado,
  output logic                           listo,
  output logic [ANCHO_DIG*NUM_DIGITOS-1:0] bcd,
  output logic                           desborde
);

  localparam int ANCHO_BCD = ANCHO_DIG * NUM_DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  estado_t                r_estado;
  estado_t                w_estado_sig;
  logic [ANCHO_BIN-1:0]   r_despl;
  logic [ANCHO_BCD-1:0]   r_acum;
  logic [ANCHO_BCD-1:0]   w_acum_aj;
  logic [ANCHO_CNT-1:0]   r_cnt;
  logic [ANCHO_BCD-1:0]   r_bcd;
  logic                   r_listo;
  logic                   r_ocupado;

  generate
    for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_dig
      ajuste_dig u_ajuste (
        .i_dig (r_acum[gi*ANCHO_DIG +: ANCHO_DIG]),
        .o_dig (w_acum_aj[gi*ANCHO_DIG +: ANCHO_DIG])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:     if (inicio) w_estado_sig = DESPLAZA;
      DESPLAZA: if (r_cnt == ANCHO_CNT'(1)) w_estado_sig = FIN;
      FIN:      w_estado_sig = IDLE;
      default:  w_estado_sig = IDLE;
    endcase
  end

`ifdef CONV_SAT_EN
  localparam int unsigned MAX_VAL = pot10(NUM_DIGITOS) - 1;
  localparam logic [ANCHO_BCD-1:0] NUEVES = {NUM_DIGITOS{4'd9}};

  logic r_sat;
  logic r_desborde;

  // Range decision is taken once at capture so the shifting datapath is untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sat      <= 1'b0;
      r_desborde <= 1'b0;
    end else begin
      if (r_estado == IDLE && inicio) begin
        r_sat <= (32'(binario) > MAX_VAL);
      end
      if (r_estado == FIN) begin
        r_desborde <= r_sat;
      end
    end
  end

  assign desborde = r_desborde;
`else
  assign desborde = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_despl   <= '0;
      r_acum    <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_listo   <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_listo <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (inicio) begin
            r_despl   <= binario;
            r_acum    <= '0;
            r_cnt     <= ANCHO_CNT'(ANCHO_BIN);
            r_ocupado <= 1'b1;
          end
        end
        DESPLAZA: begin
          // The top bit of the corrected accumulator falls off: result is modulo 10^N.
          {r_acum, r_despl} <= {w_acum_aj, r_despl} << 1;
          r_cnt             <= r_cnt - ANCHO_CNT'(1);
        end
        FIN: begin
`ifdef CONV_SAT_EN
          r_bcd <= r_sat ? NUEVES : r_acum;
`else
          r_bcd <= r_acum;
`endif
          r_listo   <= 1'b1;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign ocupado = r_ocupado;
  assign listo   = r_listo;
  assign bcd     = r_bcd;

endmodule

// File: tb/tb_conv_bin_bcd.sv
// Directed self-checking bench for conv_bin_bcd (ANCHO_BIN=8, NUM_DIGITOS=2).
// Expected values follow CONV_SAT_EN when it is defined for the build.
module tb_conv_bin_bcd;

  logic       clk;
  logic       reset_n;
  logic       inicio;
  logic [7:0] binario;
  logic       ocupado;
  logic       listo;
  logic [7:0] bcd;
  logic       desborde;

  int n_checks = 0;
  int n_errors = 0;
  int n_listo  = 0;

  conv_bin_bcd #(
    .ANCHO_BIN   (8),
    .NUM_DIGITOS (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .inicio   (inicio),
    .binario  (binario),
    .ocupado  (ocupado),
    .listo    (listo),
    .bcd      (bcd),
    .desborde (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (listo === 1'b1) n_listo++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic [7:0] exp_bcd,
                         input logic exp_des, input string tag);
    int n;
    int occ;
    int l0;
    l0      = n_listo;
    binario = v;
    inicio  = 1'b1;
    tick();
    inicio  = 1'b0;
    n       = 0;
    occ     = 0;
    while (listo !== 1'b1 && n < 30) begin
      if (ocupado === 1'b1) occ++;
      tick();
      n++;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " ocupado_cycles"}, occ, 9);
    check({tag, " bcd"}, {24'd0, bcd}, {24'd0, exp_bcd});
    check({tag, " desborde"}, {31'd0, desborde}, {31'd0, exp_des});
    tick();
    check({tag, " listo_pulse_width"}, {31'd0, listo}, 32'd0);
    check({tag, " ocupado_after"}, {31'd0, ocupado}, 32'd0);
    check({tag, " listo_count"}, n_listo - l0, 1);
    $display("conv %s: binario=%0d bcd=0x%02h desborde=%0b latency=%0d", tag, v, bcd, desborde, n);
  endtask

  initial begin
    int n;
    int l0;
    int prev;
    int pulses;
    int bad;
    logic [7:0] exp200;
    logic       des200;

`ifdef CONV_SAT_EN
    exp200 = 8'h99;
    des200 = 1'b1;
`else
    exp200 = 8'h00;
    des200 = 1'b0;
`endif

    reset_n = 1'b0;
    inicio  = 1'b0;
    binario = 8'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("reset bcd", {24'd0, bcd}, 32'h0);
    check("reset ocupado", {31'd0, ocupado}, 32'd0);
    check("reset listo", {31'd0, listo}, 32'd0);
    check("reset desborde", {31'd0, desborde}, 32'd0);
    $display("reset: bcd=0x%02h ocupado=%0b listo=%0b", bcd, ocupado, listo);

    convert(8'd57, 8'h57, 1'b0, "v57");
    convert(8'd0,  8'h00, 1'b0, "v0");
    convert(8'd9,  8'h09, 1'b0, "v9");
    convert(8'd10, 8'h10, 1'b0, "v10");
    convert(8'd99, 8'h99, 1'b0, "v99");
    convert(8'd200, exp200, des200, "v200");
    convert(8'd42, 8'h42, 1'b0, "v42");
    convert(8'd255, exp200 == 8'h99 ? 8'h99 : 8'h55, des200, "v255");

    // Second request during a conversion must be dropped.
    l0      = n_listo;
    binario = 8'd35;
    inicio  = 1'b1;
    tick();
    inicio  = 1'b0;
    repeat (3) tick();
    binario = 8'd88;
    inicio  = 1'b1;
    tick();
    inicio  = 1'b0;
    n = 0;
    while (listo !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("repulse bcd", {24'd0, bcd}, 32'h35);
    repeat (15) tick();
    check("repulse listo_count", n_listo - l0, 1);
    $display("repulse: bcd=0x%02h listo_pulses=%0d", bcd, n_listo - l0);

    // Reset in the middle of a conversion.
    binario = 8'd76;
    inicio  = 1'b1;
    tick();
    inicio  = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    check("midreset ocupado", {31'd0, ocupado}, 32'd0);
    check("midreset bcd", {24'd0, bcd}, 32'h0);
    check("midreset listo", {31'd0, listo}, 32'd0);
    reset_n = 1'b1;
    l0 = n_listo;
    repeat (12) tick();
    check("midreset no_listo", n_listo - l0, 0);
    $display("midreset: bcd=0x%02h listo_pulses=%0d", bcd, n_listo - l0);
    convert(8'd76, 8'h76, 1'b0, "v76");

    // Continuous inicio: one conversion every 10 cycles, bcd stable between pulses.
    binario = 8'd13;
    inicio  = 1'b1;
    prev    = -1;
    pulses  = 0;
    bad     = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (listo === 1'b1) begin
        pulses++;
        if (prev < 0) check("cont first_pulse", i, 9);
        else          check("cont interval", i - prev, 10);
        prev = i;
      end else if (prev >= 0 && bcd !== 8'h13) begin
        bad++;
      end
    end
    inicio = 1'b0;
    check("cont pulses", pulses, 3);
    check("cont bcd_stable", bad, 0);
    check("cont bcd", {24'd0, bcd}, 32'h13);
    $display("continuous: pulses=%0d unstable=%0d bcd=0x%02h", pulses, bad, bcd);
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_bin_bcd.md
Name: conv_bin_bcd

Overview:
- Sequential binary-to-packed-BCD encoder using shift-and-add-3 (double dabble), one input bit per clock.
- Produces the packed two-digit BCD byte consumed by the character-address decoder: tens in [7:4], units in [3:0].
- Sits between the counter/measurement logic and the display path.
- Uses a start/busy/done handshake so the display path only latches stable digits.

Parameters:
- ANCHO_BIN, 8: width of the binary input.
- NUM_DIGITOS, 2: number of BCD digits produced. Output width is 4*NUM_DIGITOS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- inicio  input  1  start request; sampled only in IDLE.
- binario  input  ANCHO_BIN  value to convert; captured on the accepted inicio cycle.
- ocupado  output  1  high while a conversion is in progress.
- listo  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*NUM_DIGITOS  packed BCD result; most significant digit in the top nibble.
- desborde  output  1  result flag; driven only when CONV_SAT_EN is defined, otherwise tied 0.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state goes to IDLE.
  - bcd = 0, listo = 0, ocupado = 0, desborde = 0.
  - Shift and counter registers are cleared.
  - Reset overrides any in-progress conversion; no listo pulse follows.
- States are IDLE, DESPLAZA and FIN.
- IDLE:
  - If inicio = 1, capture binario into the shift register, clear the BCD accumulator, set counter = ANCHO_BIN, and go to DESPLAZA.
  - ocupado rises in the next cycle.
- DESPLAZA, once per cycle:
  - For each digit, add 3 if the digit is >= 5, using 4-bit arithmetic.
  - Then shift {accumulator, shift register} left by 1 and decrement the counter.
  - When the counter reaches 1 on that edge, go to FIN.
  - Bits shifted out of the top digit are discarded, so the result is binario mod 10^NUM_DIGITOS.
- FIN:
  - Load bcd from the accumulator, pulse listo for exactly one cycle, drop ocupado, and return to IDLE.
- Latency: inicio accepted at edge k gives listo high in the cycle after edge k+ANCHO_BIN+1 (10 edges for ANCHO_BIN = 8). Back-to-back throughput is one conversion per ANCHO_BIN+2 cycles.
- inicio while ocupado = 1 or in FIN is ignored and not queued. Changes on binario after capture have no effect.
- bcd holds its last value between conversions; it changes only on the listo cycle.
- Every output digit is in the range 0..9.

Optional Feature:
- Macro: CONV_SAT_EN.
- Defined:
  - At capture, compare binario against 10^NUM_DIGITOS-1 (constant).
  - If greater, set bcd to all nines (0x99 by default) on the listo cycle, and set desborde = 1 together with listo.
  - desborde holds until the next listo.
- Undefined:
  - desborde is tied 0 and no comparator is instantiated.
  - Out-of-range inputs produce the modulo result (200 gives 0x00).

Decomposition:
- Shared package conv_pkg:
  - State encoding (IDLE, DESPLAZA, FIN).
  - Digit width constant ANCHO_DIG = 4.
  - Correction threshold 4'd5 and correction value 4'd3.
  - Function for 10^N.
- Sub-module ajuste_dig: combinational per-digit add-3 correction (4-bit in, 4-bit out), instantiated NUM_DIGITOS times via generate.

Test Plan:
- Reset held 3 cycles, then released → bcd = 0x00, ocupado = 0, listo = 0. Then binario = 57 with a one-cycle inicio → ocupado high for 9 cycles, listo single pulse, bcd = 0x57.
- Boundary values 0, 9, 10, 99, each converted sequentially → bcd = 0x00, 0x09, 0x10, 0x99. listo pulses exactly once per conversion.
- binario = 200 → without CONV_SAT_EN: bcd = 0x00, desborde = 0. With CONV_SAT_EN: bcd = 0x99, desborde = 1. A following conversion of 42 gives bcd = 0x42 and clears desborde.
- Start 35, re-pulse inicio with binario = 88 at cycle 4 of the conversion → second request ignored; bcd = 0x35, no second listo.
- Start 76, assert reset_n low at cycle 5 → next cycle: IDLE, bcd = 0x00, ocupado = 0, no listo. A later conversion of 76 gives 0x76.
- inicio held high continuously with binario = 13 → repeated conversions every 10 cycles, each with listo; bcd is stable at 0x13 between pulses.
